// File: rtl/tmds_encoder_multi.sv
// Multi-channel TMDS (DVI 8b/10b) encoder, two-stage pipeline in the pixel clock domain.
// Ports: clk_pixel, rst_n, pixel_data[C_channels*C_depth], ctl[2*C_channels], blank -> tmds[10*C_channels].
module tmds_encoder_multi #(
  parameter int C_channels = 3,
  parameter int C_depth    = 8
) (
  input  logic                            clk_pixel,
  input  logic                            rst_n,
  input  logic [C_channels*C_depth-1:0]   pixel_data,
  input  logic [2*C_channels-1:0]         ctl,
  input  logic                            blank,
  output logic [10*C_channels-1:0]        tmds
);

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Replicate the value MSB-first until 8 bits are filled.
  function automatic logic [7:0] expand(input logic [C_depth-1:0] v);
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[7-i] = v[C_depth-1-(i%C_depth)];
    return d;
  endfunction

  // Blank is common to all channels; resets to 1 so the
  // pipeline drains control tokens after reset.
  logic blank1_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) blank1_q <= 1'b1;
    else        blank1_q <= blank;
  end

  for (genvar k = 0; k < C_channels; k++) begin : g_ch
    logic [7:0]        d;
    logic [3:0]        n1d;
    logic              xn;
    logic [8:0]        qm_d;
    logic [8:0]        qm_q;
    logic [1:0]        ctl_q;
    logic [3:0]        n1q;
    logic signed [4:0] diff;
    logic signed [4:0] bias;
    logic signed [4:0] nbias;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [9:0]        tmds_d;
    logic [9:0]        tmds_q;
    logic              bal;
    logic              flip;
    logic              keep;

    always_comb begin
      d    = expand(pixel_data[k*C_depth +: C_depth]);
      n1d  = ones8(d);
      xn   = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      qm_d = '0;
      qm_d[0] = d[0];
      for (int i = 1; i < 8; i++) begin
        qm_d[i] = xn ? ~(qm_d[i-1] ^ d[i])
                     :  (qm_d[i-1] ^ d[i]);
      end
      qm_d[8] = ~xn;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
        qm_q  <= '0;
        ctl_q <= '0;
      end else begin
        qm_q  <= qm_d;
        ctl_q <= ctl[2*k +: 2];
      end
    end

    always_comb begin
      n1q   = ones8(qm_q[7:0]);
      // n1 - n0 = 2*n1 - 8, wraps correctly in 5 bits
      diff  = $signed({n1q, 1'b0}) - 5'sd8;
      bias  = $signed({3'b000, qm_q[8], 1'b0});
      nbias = $signed({3'b000, ~qm_q[8], 1'b0});
      bal   = (cnt_q == 5'sd0) || (diff == 5'sd0);
      flip  = !bal &&
              (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
               ((cnt_q < 5'sd0) && (diff < 5'sd0)));
      keep  = !bal && !flip;
      tmds_d = TOK00;
      cnt_d  = cnt_q;
      if (blank1_q) begin
        cnt_d = 5'sd0;
        unique case (ctl_q)
          2'b00: tmds_d = TOK00;
          2'b01: tmds_d = TOK01;
          2'b10: tmds_d = TOK10;
          2'b11: tmds_d = TOK11;
          default: tmds_d = TOK00;
        endcase
      end else begin
        unique case (1'b1)
          bal: begin
            tmds_d = {~qm_q[8], qm_q[8],
                      qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? diff : -diff);
          end
          flip: begin
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + bias - diff;
          end
          keep: begin
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + diff - nbias;
          end
          default: begin
            tmds_d = TOK00;
            cnt_d  = cnt_q;
          end
        endcase
      end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
        tmds_q <= TOK00;
        cnt_q  <= 5'sd0;
      end else begin
        tmds_q <= tmds_d;
        cnt_q  <= cnt_d;
      end
    end

    assign tmds[10*k +: 10] = tmds_q;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Testbench for tmds_encoder_multi: three configurations checked
// against a behavioural DVI encoder model through a scoreboard queue.
module tb_tmds_encoder_multi;

  localparam logic [9:0] TOK0 = 10'h354;

  logic        clk_pixel = 1'b0;
  logic        rst_n     = 1'b1;
  logic        blank     = 1'b1;
  logic [23:0] pd_a      = '0;
  logic [5:0]  ctl_a     = '0;
  logic [29:0] tmds_a;
  logic [2:0]  pd_b      = '0;
  logic [1:0]  ctl_b     = '0;
  logic [9:0]  tmds_b;
  logic [3:0]  pd_c      = '0;
  logic [7:0]  ctl_c     = '0;
  logic [39:0] tmds_c;

  int checks = 0;
  int errors = 0;
  int cnt_m[8];

  typedef struct {
    logic [29:0] a;
    logic [9:0]  b;
    logic [39:0] c;
    logic        vid;
    logic [23:0] da;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic       b;
    logic [1:0] c;
    logic [7:0] p;
    logic [9:0] e;
  } vec_t;

  vec_t tab[15];

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder_multi #(.C_channels(3), .C_depth(8)) dut_a (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .pixel_data(pd_a),
    .ctl       (ctl_a),
    .blank     (blank),
    .tmds      (tmds_a)
  );

  tmds_encoder_multi #(.C_channels(1), .C_depth(3)) dut_b (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .pixel_data(pd_b),
    .ctl       (ctl_b),
    .blank     (blank),
    .tmds      (tmds_b)
  );

  tmds_encoder_multi #(.C_channels(4), .C_depth(1)) dut_c (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .pixel_data(pd_c),
    .ctl       (ctl_c),
    .blank     (blank),
    .tmds      (tmds_c)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Shift-accumulate replication, then keep the top 8 bits.
  function automatic logic [7:0] expand_m(input int depth, input int v);
    int acc;
    int bits;
    acc = 0;
    bits = 0;
    while (bits < 8) begin
      acc = (acc << depth) | v;
      bits += depth;
    end
    return 8'(acc >> (bits - 8));
  endfunction

  function automatic logic [7:0] dec(input logic [9:0] w);
    logic [7:0] x;
    logic [7:0] d;
    x = w[9] ? ~w[7:0] : w[7:0];
    d[0] = x[0];
    for (int i = 1; i < 8; i++)
      d[i] = w[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    return d;
  endfunction

  task automatic model(input int depth, input int idx, input int v,
                       input logic [1:0] c, input logic b,
                       output logic [9:0] w);
    logic [7:0] d;
    logic [8:0] q;
    int n1;
    int n1q;
    int n0q;
    int cnt;
    cnt = cnt_m[idx];
    if (b) begin
      case (c)
        2'b00: w = 10'b1101010100;
        2'b01: w = 10'b0010101011;
        2'b10: w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
      cnt = 0;
    end else begin
      d = expand_m(depth, v);
      n1 = $countones(d);
      q[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
        for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
        q[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
        q[8] = 1'b1;
      end
      n1q = $countones(q[7:0]);
      n0q = 8 - n1q;
      if (cnt == 0 || n1q == n0q) begin
        w[9] = ~q[8];
        w[8] = q[8];
        w[7:0] = q[8] ? q[7:0] : ~q[7:0];
        cnt = q[8] ? cnt + n1q - n0q : cnt + n0q - n1q;
      end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
        w = {1'b1, q[8], ~q[7:0]};
        cnt = cnt + 2 * int'(q[8]) + n0q - n1q;
      end else begin
        w = {1'b0, q[8], q[7:0]};
        cnt = cnt + n1q - n0q - 2 * int'(!q[8]);
      end
    end
    cnt_m[idx] = cnt;
  endtask

  task automatic restart();
    sb_t e;
    sbq.delete();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    e.a = {3{TOK0}};
    e.b = TOK0;
    e.c = {4{TOK0}};
    e.vid = 1'b0;
    e.da = '0;
    sbq.push_back(e);
  endtask

  task automatic step(input logic b, input logic [23:0] pa,
                      input logic [5:0] ca, input logic [2:0] pb,
                      input logic [1:0] cb, input logic [3:0] pc,
                      input logic [7:0] cc, input bit use_tab,
                      input logic [9:0] tab_w);
    sb_t e;
    logic [9:0] w;
    blank = b;
    pd_a = pa;
    ctl_a = ca;
    pd_b = pb;
    ctl_b = cb;
    pd_c = pc;
    ctl_c = cc;
    for (int k = 0; k < 3; k++) begin
      model(8, k, int'(pa[8*k +: 8]), ca[2*k +: 2], b, w);
      e.a[10*k +: 10] = use_tab ? tab_w : w;
      e.da[8*k +: 8] = pa[8*k +: 8];
    end
    model(3, 3, int'(pb), cb, b, w);
    e.b = w;
    for (int k = 0; k < 4; k++) begin
      model(1, 4 + k, int'(pc[k]), cc[2*k +: 2], b, w);
      e.c[10*k +: 10] = w;
    end
    e.vid = !b;
    sbq.push_back(e);
    @(negedge clk_pixel);
    if (sbq.size() > 1) begin
      e = sbq.pop_front();
      chk("tmds_a", 64'(tmds_a), 64'(e.a));
      chk("tmds_b", 64'(tmds_b), 64'(e.b));
      chk("tmds_c", 64'(tmds_c), 64'(e.c));
      if (e.vid) begin
        for (int k = 0; k < 3; k++)
          chk("decode_a", 64'(dec(tmds_a[10*k +: 10])),
              64'(e.da[8*k +: 8]));
      end
    end
  endtask

  initial begin
    logic bk;
    tab[0]  = '{1'b1, 2'b00, 8'h00, 10'h354};
    tab[1]  = '{1'b1, 2'b00, 8'h5A, 10'h354};
    tab[2]  = '{1'b1, 2'b01, 8'h00, 10'h0AB};
    tab[3]  = '{1'b1, 2'b10, 8'hFF, 10'h154};
    tab[4]  = '{1'b1, 2'b11, 8'h00, 10'h2AB};
    tab[5]  = '{1'b1, 2'b00, 8'h00, 10'h354};
    tab[6]  = '{1'b0, 2'b00, 8'h00, 10'h100};
    tab[7]  = '{1'b0, 2'b11, 8'h00, 10'h3FF};
    tab[8]  = '{1'b0, 2'b01, 8'h00, 10'h100};
    tab[9]  = '{1'b0, 2'b10, 8'h00, 10'h3FF};
    tab[10] = '{1'b0, 2'b00, 8'h00, 10'h100};
    tab[11] = '{1'b0, 2'b11, 8'h00, 10'h3FF};
    tab[12] = '{1'b1, 2'b01, 8'h00, 10'h0AB};
    tab[13] = '{1'b0, 2'b10, 8'h00, 10'h100};
    tab[14] = '{1'b0, 2'b00, 8'h00, 10'h3FF};

    #1 rst_n = 1'b0;
    repeat (4) begin
      blank = 1'($urandom);
      pd_a = 24'($urandom);
      ctl_a = 6'($urandom);
      pd_b = 3'($urandom);
      ctl_b = 2'($urandom);
      pd_c = 4'($urandom);
      ctl_c = 8'($urandom);
      @(negedge clk_pixel);
      chk("reset_a", 64'(tmds_a), 64'({3{TOK0}}));
      chk("reset_b", 64'(tmds_b), 64'(TOK0));
      chk("reset_c", 64'(tmds_c), 64'({4{TOK0}}));
    end
    blank = 1'b1;
    ctl_a = '0;
    ctl_b = '0;
    ctl_c = '0;
    #1 rst_n = 1'b1;
    restart();

    for (int i = 0; i < 15; i++)
      step(tab[i].b, {3{tab[i].p}}, {3{tab[i].c}}, 3'b101,
           tab[i].c, 4'hF, {4{tab[i].c}}, 1'b1, tab[i].e);

    step(1'b1, 24'h0000B6, 6'h0, 3'b101, 2'b00, 4'h0, 8'h0, 1'b0, 10'h0);
    repeat (12)
      step(1'b0, 24'h0000B6, 6'h0, 3'b101, 2'b00, 4'h5, 8'h0, 1'b0, 10'h0);

    repeat (5)
      step(1'b0, 24'($urandom), 6'($urandom), 3'($urandom),
           2'($urandom), 4'($urandom), 8'($urandom), 1'b0, 10'h0);
    #1 rst_n = 1'b0;
    #2;
    chk("async_rst_a", 64'(tmds_a), 64'({3{TOK0}}));
    chk("async_rst_b", 64'(tmds_b), 64'(TOK0));
    chk("async_rst_c", 64'(tmds_c), 64'({4{TOK0}}));
    #1 rst_n = 1'b1;
    restart();
    repeat (6)
      step(1'b0, 24'($urandom), 6'($urandom), 3'($urandom),
           2'($urandom), 4'($urandom), 8'($urandom), 1'b0, 10'h0);

    bk = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) bk = ~bk;
      step(bk, 24'($urandom), 6'($urandom), 3'($urandom),
           2'($urandom), 4'($urandom), 8'($urandom), 1'b0, 10'h0);
    end
    step(1'b1, 24'h0, 6'h0, 3'h0, 2'h0, 4'h0, 8'h0, 1'b0, 10'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_multi.md
# tmds_encoder_multi

Parametrised multi-channel TMDS (DVI 8b/10b) encoder that generates the 10-bit words consumed by the SDR/DDR serializers feeding the gpdi differential pairs. It is the successor of the fixed 3-channel VGA-to-HDMI front end. New in this block:
- configurable channel count and input colour depth, with bit-replication expansion to 8 bits;
- per-channel DC-balance (running disparity) tracking;
- per-channel control-token inputs, for HDMI preambles beyond hsync/vsync.

It runs entirely in the pixel clock domain, ahead of the serializer.

## Interface
Parameters:
- C_channels, 3 — number of TMDS data channels (1..4); channel 0 = blue, 1 = green, 2 = red.
- C_depth, 8 — input bits per channel (1..8), expanded to 8 bits internally.

Ports:
- clk_pixel  in  1 — pixel clock; the only clock.
- rst_n  in  1 — asynchronous, active-low reset.
- pixel_data  in  C_channels*C_depth — channel k occupies bits [k*C_depth +: C_depth], MSB first.
- ctl  in  2*C_channels — control pair per channel, [2k+1:2k] = {c1,c0}; channel 0 carries {vsync,hsync}.
- blank  in  1 — 1 = control period (emit tokens), 0 = video period.
- tmds  out  10*C_channels — encoded word per channel at [10k +: 10], bit 0 transmitted first.

## Operation
- Expansion: the C_depth-bit value v is repeated from the MSB down to fill 8 bits.
  - C_depth=3, v=101 -> 10110110.
  - C_depth=1, v=1 -> 11111111.
  - C_depth=8 passes v through unchanged.
- Stage 1 registers, per channel:
  - Count N1(D) of the expanded byte D.
  - If N1>4, or N1==4 with D[0]==0: q_m is an XNOR chain and q_m[8]=0.
  - Otherwise: q_m is an XOR chain and q_m[8]=1. In both cases q_m[0]=D[0].
  - blank and ctl are delayed alongside q_m.
- Stage 2, per channel, with cnt a 5-bit signed running disparity and n1/n0 the ones/zeros count of q_m[7:0]:
  - If cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? n1-n0 : n0-n1.
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2*q_m[8] + n0-n1.
  - Else:
    - out = {0, q_m[8], q_m[7:0]};
    - cnt += n1-n0 - 2*(~q_m[8]).
- Control period: when delayed blank=1, stage 2 emits a token selected by {c1,c0} and clears cnt to 0:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- Channels are fully independent; each has its own cnt.
- Arithmetic: n1-n0 is an even value in -8..+8 and is sign-extended to 5 bits. cnt always stays even, and its range fits within -16..+15.

## Timing
- Fixed latency of 2 clk_pixel cycles from pixel_data/ctl/blank to tmds, in both video and control periods.
- No handshake: one word per channel on every cycle.
- Reset (rst_n=0, asynchronous assert):
  - tmds = 1101010100 on every channel;
  - all cnt = 0;
  - pipeline blank registers = 1.
- Deassert is sampled on clk_pixel. The first two output words after deassert are control tokens for ctl=00, irrespective of the inputs.
- Reset asserted mid-line forces the reset token immediately, with no partial word.
- Blank transitions:
  - 1->0: the first video word is encoded with cnt=0.
  - 0->1: the token appears exactly 2 cycles after blank rises, and cnt is already 0 for the next video word.
- Changing ctl while blank=0 has no effect on the output.

## Test plan
- Reset: hold rst_n=0 with random inputs -> every channel reads 0x354 (1101010100). After release with blank=1, ctl=00, output stays 0x354.
- Disparity sequence: blank=1, then blank=0 with pixel_data=0x00 on channel 0 (C_depth=8) -> outputs begin exactly 2 cycles after blank falls and read 0x100, 0x3FF, 0x100, 0x3FF…
- Tokens: blank=1, sweep ctl through 00/01/10/11 on all channels -> 0x354, 0x0AB, 0x154, 0x2AB (binary 1101010100, 0010101011, 0101010100, 1010101011), each 2 cycles after the stimulus.
- Expansion: C_depth=3, channel 0 = 101 -> identical output stream to a C_depth=8 instance fed 0xB6.
- Random compare: 100k random pixels with random blank bursts, for C_channels in {1,3,4} and C_depth in {1,3,8} -> bit-exact against the behavioural DVI 1.0 encoder model; cnt stays even; decoded data equals the expanded input.
- Mid-operation reset: pulse rst_n low for half a clk_pixel period during video -> token 0x354 appears asynchronously. After release, the first video word is encoded as if cnt=0.
